// File: rtl/ad9434_pkg.sv
// ad9434_pkg: shared constants, FSM state type and centre-tap helper for IDELAY calibration
package ad9434_pkg;
  localparam int NUM_TAPS = 32;
  localparam int TAP_W = 5;
  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_RDY, S_LOAD, S_SETTLE, S_CHECK, S_EVAL, S_APPLY, S_APPLY_WAIT, S_DONE
  } calib_state_t;
  function automatic logic [TAP_W-1:0] centre_tap(input logic [TAP_W-1:0] s, input logic [TAP_W:0] len);
    logic [TAP_W:0] c;
    c = {1'b0, s} + (len >> 1);
    return c[TAP_W-1:0];
  endfunction
endpackage

// File: rtl/ad9434_idelay_calib_if.sv
// ad9434_idelay_calib_if: control, capture data and IDELAY load signals of the calibration block
interface ad9434_idelay_calib_if
  import ad9434_pkg::*;
#(parameter int NUM_LANES = 6);
  logic                     start;
  logic                     idelayctrl_rdy;
  logic [NUM_LANES-1:0]     q1, q2, exp_q1, exp_q2;
  logic [NUM_LANES-1:0]     idelay_ld;
  logic [TAP_W-1:0]         idelay_cntvalue;
  logic                     busy, done;
  logic [NUM_LANES-1:0]     lane_err;
  logic [TAP_W*NUM_LANES-1:0] tap_out;
  modport master (output start, idelayctrl_rdy, q1, q2, exp_q1, exp_q2,
                  input idelay_ld, idelay_cntvalue, busy, done, lane_err, tap_out);
  modport slave  (input start, idelayctrl_rdy, q1, q2, exp_q1, exp_q2,
                  output idelay_ld, idelay_cntvalue, busy, done, lane_err, tap_out);
endinterface

// File: rtl/ad9434_eye_finder.sv
// ad9434_eye_finder: serial longest-run-of-ones search over the 32-tap pass window
module ad9434_eye_finder
  import ad9434_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [NUM_TAPS-1:0] window_i,
  output logic [TAP_W-1:0]    best_start_o,
  output logic [TAP_W:0]      best_len_o,
  output logic                valid_o
);
  logic run_q, run_d, valid_q, valid_d, hit;
  logic [TAP_W-1:0] idx_q, idx_d, cur_start_q, cur_start_d, best_start_q, best_start_d, ext_start;
  logic [TAP_W:0] cur_len_q, cur_len_d, best_len_q, best_len_d, ext_len;
  assign hit = window_i[idx_q];
  assign ext_len = cur_len_q + 1'b1;
  assign ext_start = cur_len_q == '0 ? idx_q : cur_start_q;
  // strict > while a run grows keeps the earliest of equal-length runs
  always_comb begin
    run_d = run_q;
    valid_d = valid_q;
    idx_d = idx_q;
    cur_len_d = cur_len_q;
    cur_start_d = cur_start_q;
    best_start_d = best_start_q;
    best_len_d = best_len_q;
    if (start_i) begin
      run_d = 1'b1;
      valid_d = 1'b0;
      idx_d = '0;
      cur_len_d = '0;
      cur_start_d = '0;
      best_start_d = '0;
      best_len_d = '0;
    end else if (run_q) begin
      idx_d = idx_q + 1'b1;
      cur_len_d = hit ? ext_len : '0;
      cur_start_d = ext_start;
      best_len_d = hit && ext_len > best_len_q ? ext_len : best_len_q;
      best_start_d = hit && ext_len > best_len_q ? ext_start : best_start_q;
      run_d = idx_q != TAP_W'(NUM_TAPS-1);
      valid_d = idx_q == TAP_W'(NUM_TAPS-1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      valid_q <= 1'b0;
      idx_q <= '0;
      cur_len_q <= '0;
      cur_start_q <= '0;
      best_start_q <= '0;
      best_len_q <= '0;
    end else begin
      run_q <= run_d;
      valid_q <= valid_d;
      idx_q <= idx_d;
      cur_len_q <= cur_len_d;
      cur_start_q <= cur_start_d;
      best_start_q <= best_start_d;
      best_len_q <= best_len_d;
    end
  end
  assign best_start_o = best_start_q;
  assign best_len_o = best_len_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/ad9434_idelay_calib.sv
// ad9434_idelay_calib: per-lane IDELAYE2 tap sweep, pass-window search and centre-tap load
module ad9434_idelay_calib
  import ad9434_pkg::*;
#(
  parameter int NUM_LANES   = 6,
  parameter int SETTLE_CYC  = 16,
  parameter int SAMPLES     = 1024,
  parameter int MIN_EYE     = 4,
  parameter int DEFAULT_TAP = 1
) (
  input logic adc_clk,
  input logic rst,
  ad9434_idelay_calib_if.slave bus
);
  localparam int LANE_W = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLES - 1);
  localparam logic [TAP_W:0] MIN_EYE_L = (TAP_W+1)'(MIN_EYE);
  localparam logic [TAP_W-1:0] DEF_TAP = TAP_W'(DEFAULT_TAP);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANES - 1);
  localparam logic [NUM_LANES-1:0] ONE = NUM_LANES'(1);
  calib_state_t state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [TAP_W-1:0] tap_q, tap_d, apply_tap, best_start;
  logic [TAP_W:0] best_len;
  logic [15:0] cnt_q, cnt_d;
  logic fail_q, fail_d, done_q, done_d, eye_start, eye_valid, mismatch, apply_bad, abort;
  logic [NUM_TAPS-1:0] window_q, window_d;
  logic [NUM_LANES-1:0] lane_err_q, lane_err_d;
  logic [TAP_W*NUM_LANES-1:0] tap_out_q, tap_out_d;
  ad9434_eye_finder u_eye (
    .clk(adc_clk), .rst(rst), .start_i(eye_start), .window_i(window_q),
    .best_start_o(best_start), .best_len_o(best_len), .valid_o(eye_valid)
  );
  assign mismatch = bus.q1[lane_q] != bus.exp_q1[lane_q] || bus.q2[lane_q] != bus.exp_q2[lane_q];
  assign apply_bad = !eye_valid || best_len < MIN_EYE_L;
  assign apply_tap = apply_bad ? DEF_TAP : centre_tap(best_start, best_len);
  // once DONE is reached the run is complete, so a late RDY drop no longer restarts a lane
  assign abort = !bus.idelayctrl_rdy && !(state_q inside {S_IDLE, S_WAIT_RDY, S_DONE});
  always_comb begin
    state_d = state_q;
    lane_d = lane_q;
    tap_d = tap_q;
    cnt_d = cnt_q + 16'd1;
    fail_d = fail_q;
    window_d = window_q;
    done_d = done_q;
    lane_err_d = lane_err_q;
    tap_out_d = tap_out_q;
    eye_start = 1'b0;
    if (abort) state_d = S_WAIT_RDY;
    else case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_WAIT_RDY;
        lane_d = '0;
        done_d = 1'b0;
        lane_err_d = '0;
        tap_out_d = '0;
      end
      S_WAIT_RDY: if (bus.idelayctrl_rdy) begin
        state_d = S_LOAD;
        tap_d = '0;
      end
      S_LOAD: begin
        state_d = S_SETTLE;
        cnt_d = '0;
      end
      S_SETTLE: if (cnt_q == SETTLE_LAST) begin
        state_d = S_CHECK;
        cnt_d = '0;
        fail_d = 1'b0;
      end
      S_CHECK: begin
        fail_d = fail_q | mismatch;
        if (cnt_q == SAMPLE_LAST) begin
          window_d[tap_q] = !fail_d;
          cnt_d = '0;
          tap_d = tap_q + 1'b1;
          state_d = tap_q == LAST_TAP ? S_EVAL : S_LOAD;
          eye_start = tap_q == LAST_TAP;
        end
      end
      S_EVAL: if (cnt_q == 16'(NUM_TAPS - 1)) state_d = S_APPLY;
      S_APPLY: begin
        state_d = S_APPLY_WAIT;
        cnt_d = '0;
        lane_err_d[lane_q] = apply_bad;
        tap_out_d[TAP_W*lane_q +: TAP_W] = apply_tap;
      end
      S_APPLY_WAIT: if (cnt_q == SETTLE_LAST) begin
        state_d = lane_q == LANE_LAST ? S_DONE : S_LOAD;
        done_d = lane_q == LANE_LAST;
        lane_d = lane_q + 1'b1;
        tap_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lane_q <= '0;
      tap_q <= '0;
      cnt_q <= '0;
      fail_q <= 1'b0;
      window_q <= '0;
      done_q <= 1'b0;
      lane_err_q <= '0;
      tap_out_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      tap_q <= tap_d;
      cnt_q <= cnt_d;
      fail_q <= fail_d;
      window_q <= window_d;
      done_q <= done_d;
      lane_err_q <= lane_err_d;
      tap_out_q <= tap_out_d;
    end
  end
  assign bus.idelay_ld = state_q inside {S_LOAD, S_APPLY} ? ONE << lane_q : '0;
  assign bus.idelay_cntvalue = state_q == S_APPLY ? apply_tap : state_q == S_LOAD ? tap_q : '0;
  assign bus.busy = !(state_q inside {S_IDLE, S_DONE});
  assign bus.done = done_q;
  assign bus.lane_err = lane_err_q;
  assign bus.tap_out = tap_out_q;
endmodule

// File: tb/tb_ad9434_idelay_calib.sv
// tb_ad9434_idelay_calib: randomized tap-window channel model against a longest-eye reference
module tb_ad9434_idelay_calib;
  localparam int NL = 6;
  localparam int SETTLE = 4;
  localparam int SAMP = 8;
  localparam int PER_LANE = 32 * (1 + SETTLE + SAMP) + 32 + 1 + SETTLE;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int viol = 0;
  int first_ld = -1;
  logic [31:0] win [NL];
  logic [4:0] cur_tap [NL];
  int tap0_lds [NL];
  ad9434_idelay_calib_if #(.NUM_LANES(NL)) bus ();
  ad9434_idelay_calib #(
    .NUM_LANES(NL), .SETTLE_CYC(SETTLE), .SAMPLES(SAMP), .MIN_EYE(4), .DEFAULT_TAP(1)
  ) dut (.adc_clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rmask(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int t = lo; t <= hi; t++) m[t] = 1'b1;
    return m;
  endfunction
  // reference: enumerate every run by its start, keep the first strictly longest
  function automatic logic [5:0] model_lane(input logic [31:0] w);
    int bs = 0;
    int bl = 0;
    for (int s = 0; s < 32; s++) begin
      if (w[s] && (s == 0 || !w[s-1])) begin
        int l = 0;
        while (s + l < 32 && w[s+l]) l++;
        if (l > bl) begin
          bl = l;
          bs = s;
        end
      end
    end
    return bl < 4 ? {1'b1, 5'd1} : {1'b0, 5'(bs + bl / 2)};
  endfunction
  // channel: a lane's data is corrupted whenever its loaded tap lies outside its window
  initial begin
    for (int l = 0; l < NL; l++) cur_tap[l] = '0;
    bus.q1 = '0;
    bus.q2 = '0;
    forever begin
      @(negedge clk);
      if (bus.idelay_ld != '0) begin
        if ($countones(bus.idelay_ld) != 1) viol++;
        if (first_ld < 0) first_ld = cyc;
        for (int l = 0; l < NL; l++) if (bus.idelay_ld[l]) begin
          cur_tap[l] = bus.idelay_cntvalue;
          if (bus.idelay_cntvalue == 5'd0) tap0_lds[l]++;
        end
      end
      for (int l = 0; l < NL; l++) begin
        logic [31:0] r;
        logic bad;
        r = $urandom;
        bad = !win[l][cur_tap[l]];
        bus.q1[l] = bus.exp_q1[l] ^ (bad & r[0]);
        bus.q2[l] = bus.exp_q2[l] ^ (bad & ~r[0]);
      end
    end
  end
  task automatic all_pass();
    for (int l = 0; l < NL; l++) win[l] = '1;
  endtask
  task automatic launch();
    viol = 0;
    first_ld = -1;
    for (int l = 0; l < NL; l++) tap0_lds[l] = 0;
    bus.exp_q1 = 6'($urandom);
    bus.exp_q2 = 6'($urandom);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask
  task automatic finish_run(input string tag, input bit chk_cycles);
    int done_cyc = -1;
    logic [5:0] m;
    logic [5:0] exp_err;
    for (int i = 0; i < PER_LANE * NL + 600; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0) check({tag, "_done_timeout"}, 32'(bus.done), 32'd1);
    else begin
      for (int l = 0; l < NL; l++) begin
        m = model_lane(win[l]);
        exp_err[l] = m[5];
        check($sformatf("%s_tap%0d", tag, l), 32'(bus.tap_out[5*l +: 5]), 32'(m[4:0]));
        check($sformatf("%s_ldval%0d", tag, l), 32'(cur_tap[l]), 32'(m[4:0]));
      end
      check({tag, "_lane_err"}, 32'(bus.lane_err), 32'(exp_err));
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_onehot"}, 32'(viol), 32'd0);
      if (chk_cycles) check({tag, "_cycles"}, 32'(done_cyc - first_ld), 32'(PER_LANE * NL));
      repeat (3) @(posedge clk);
      #1 check({tag, "_done_hold"}, 32'(bus.done), 32'd1);
    end
  endtask
  task automatic wait_ld(input int lane, input int tap, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < PER_LANE * NL; i++) begin
      @(negedge clk);
      if (bus.idelay_ld[lane] && (tap < 0 || int'(bus.idelay_cntvalue) == tap)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  initial begin
    bit ok;
    bus.start = 1'b0;
    bus.idelayctrl_rdy = 1'b1;
    bus.exp_q1 = '0;
    bus.exp_q2 = '0;
    all_pass();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ld", 32'(bus.idelay_ld), 32'd0);
    check("rst_tap_out", 32'(bus.tap_out), 32'd0);
    check("rst_lane_err", 32'(bus.lane_err), 32'd0);
    @(negedge clk) rst = 1'b0;
    // scenario 1, entered with RDY low to exercise the WAIT_RDY hold
    bus.idelayctrl_rdy = 1'b0;
    launch();
    repeat (5) @(negedge clk);
    check("s1_wait_ld", 32'(bus.idelay_ld), 32'd0);
    check("s1_wait_busy", 32'(bus.busy), 32'd1);
    bus.idelayctrl_rdy = 1'b1;
    finish_run("s1", 1'b1);
    all_pass();
    win[2] = rmask(5, 14);
    launch();
    finish_run("s2", 1'b1);
    check("s2_lane2_tap", 32'(bus.tap_out[14:10]), 32'd10);
    all_pass();
    win[0] = rmask(3, 6) | rmask(20, 23) | rmask(29, 31);
    launch();
    finish_run("s3", 1'b1);
    check("s3_lane0_tap", 32'(bus.tap_out[4:0]), 32'd5);
    all_pass();
    win[5] = rmask(8, 10);
    launch();
    finish_run("s4", 1'b1);
    check("s4_lane_err", 32'(bus.lane_err), 32'h20);
    check("s4_lane5_tap", 32'(bus.tap_out[29:25]), 32'd1);
    check("s4_lane5_ld", 32'(cur_tap[5]), 32'd1);
    for (int r = 0; r < 2; r++) begin
      for (int l = 0; l < NL; l++) begin
        int s = $urandom_range(0, 31);
        int n = $urandom_range(0, 14);
        win[l] = (n == 0 ? 32'd0 : rmask(s, s + n - 1 > 31 ? 31 : s + n - 1)) | ($urandom & $urandom & $urandom);
      end
      launch();
      finish_run($sformatf("rnd%0d", r), 1'b1);
    end
    // scenario 5: async reset while lane 3 is checking
    all_pass();
    launch();
    wait_ld(3, -1, ok);
    check("s5_reach_lane3", 32'(ok), 32'd1);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("s5_busy", 32'(bus.busy), 32'd0);
    check("s5_ld", 32'(bus.idelay_ld), 32'd0);
    check("s5_tap_out", 32'(bus.tap_out), 32'd0);
    check("s5_done", 32'(bus.done), 32'd0);
    @(negedge clk) rst = 1'b0;
    launch();
    finish_run("s5", 1'b1);
    // scenario 6: start re-pulsed while busy, RDY dropped mid lane 1
    launch();
    repeat (20) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    check("s6_busy", 32'(bus.busy), 32'd1);
    wait_ld(1, 10, ok);
    check("s6_reach_lane1", 32'(ok), 32'd1);
    @(negedge clk) bus.idelayctrl_rdy = 1'b0;
    repeat (10) @(negedge clk);
    bus.idelayctrl_rdy = 1'b1;
    finish_run("s6", 1'b0);
    for (int l = 0; l < NL; l++)
      check($sformatf("s6_tap0_loads%0d", l), 32'(tap0_lds[l]), l == 1 ? 32'd2 : 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
